// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit.
package lsu_pkg;

  // mem_op[1:0] access size
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // mem_op flag bit positions
  localparam int OP_UNS = 2;
  localparam int OP_ST  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store replication/strobes, load extraction
// with sign/zero extension, and the misalignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [31:0] ld_shift;
  logic [15:0] ld_half;

  // Store lane replication and byte enables
  always_comb begin
    wdata = st_data;
    wstrb = 4'b1111;
    case (size)
      SZ_B: begin
        wdata = {4{st_data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      SZ_H: begin
        wdata = {2{st_data[15:0]}};
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = st_data;
        wstrb = 4'b1111;
      end
    endcase
  end

  // Load lane selection and extension
  always_comb begin
    ld_shift = ld_word >> {addr_lo, 3'b000};
    ld_half  = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data  = ld_word;
    case (size)
      SZ_B:    ld_data = {{24{~uns & ld_shift[7]}}, ld_shift[7:0]};
      SZ_H:    ld_data = {{16{~uns & ld_half[15]}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

  // Misaligned halves/words and the illegal size encoding
  always_comb begin
    misalign = 1'b0;
    case (size)
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = addr_lo[0];
      SZ_W:    misalign = (addr_lo != 2'b00);
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts memory ops from execute, runs the dmem
// request/grant/response handshake and returns extended load data.
module lsu
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [3:0]    mem_op,
  input  logic [AW-1:0] ex_addr,
  input  logic [DW-1:0] ex_wdata,
  input  logic [4:0]    ex_rd,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic [3:0]    dmem_wstrb,
  input  logic          dmem_gnt,
  input  logic          dmem_rvalid,
  input  logic [DW-1:0] dmem_rdata,
  output logic          wb_valid,
  output logic [4:0]    wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          misalign,
  output logic [AW-1:0] misalign_addr,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          st_q, st_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [4:0]    rd_q, rd_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          wb_valid_q, wb_valid_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          misalign_q, misalign_d;
  logic [AW-1:0] misalign_addr_q, misalign_addr_d;

  logic          idle;
  logic          accept;
  logic [1:0]    al_size;
  logic          al_uns;
  logic [1:0]    al_addr_lo;
  logic [DW-1:0] al_wdata;
  logic [3:0]    al_wstrb;
  logic [DW-1:0] al_ld_data;
  logic          al_misalign;

  assign idle   = (state_q == ST_IDLE);
  assign accept = ex_valid & idle;

  // The single aligner serves the incoming op while idle (misalign check,
  // store lanes latched at accept) and the latched op otherwise (load extract).
  assign al_size    = idle ? mem_op[1:0]    : size_q;
  assign al_uns     = idle ? mem_op[OP_UNS] : uns_q;
  assign al_addr_lo = idle ? ex_addr[1:0]   : addr_q[1:0];

  lsu_align u_align (
    .size     (al_size),
    .uns      (al_uns),
    .addr_lo  (al_addr_lo),
    .st_data  (ex_wdata),
    .ld_word  (dmem_rdata),
    .wdata    (al_wdata),
    .wstrb    (al_wstrb),
    .ld_data  (al_ld_data),
    .misalign (al_misalign)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d         = state_q;
    size_d          = size_q;
    uns_d           = uns_q;
    st_d            = st_q;
    addr_d          = addr_q;
    rd_d            = rd_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    wb_valid_d      = 1'b0;
    wb_rd_d         = wb_rd_q;
    wb_data_d       = wb_data_q;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (al_misalign) begin
            misalign_d      = 1'b1;
            misalign_addr_d = ex_addr;
          end else begin
            size_d  = mem_op[1:0];
            uns_d   = mem_op[OP_UNS];
            st_d    = mem_op[OP_ST];
            addr_d  = ex_addr;
            rd_d    = ex_rd;
            wdata_d = al_wdata;
            wstrb_d = mem_op[OP_ST] ? al_wstrb : 4'b0000;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dmem_gnt) state_d = st_q ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_data_d  = al_ld_data;
          wb_rd_d    = rd_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      size_q          <= '0;
      uns_q           <= 1'b0;
      st_q            <= 1'b0;
      addr_q          <= '0;
      rd_q            <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= '0;
      wb_data_q       <= '0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      size_q          <= size_d;
      uns_q           <= uns_d;
      st_q            <= st_d;
      addr_q          <= addr_d;
      rd_q            <= rd_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      wb_valid_q      <= wb_valid_d;
      wb_rd_q         <= wb_rd_d;
      wb_data_q       <= wb_data_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign busy          = ~idle;
  assign ex_ready      = idle;
  assign dmem_req      = (state_q == ST_REQ);
  assign dmem_we       = dmem_req & st_q;
  assign dmem_addr     = {addr_q[AW-1:2], 2'b00};
  assign dmem_wdata    = wdata_q;
  assign dmem_wstrb    = wstrb_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the execute stage in the RISC-V core. It takes the ALU-computed effective address, the store data and a memory opcode from execute. It then drives a variable-latency data-memory request/grant/response interface and returns aligned, sign- or zero-extended load data to writeback. It also stalls the pipeline while a request is outstanding and flags misaligned accesses.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width; fixed at 32 for RV32.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `ex_valid`  in  1  execute presents a memory op this cycle.
- `ex_ready`  out  1  LSU accepts; op is taken when `ex_valid & ex_ready`.
- `mem_op`  in  4  bits [1:0] size (00 byte, 01 half, 10 word, 11 illegal); [2] unsigned load; [3] store.
- `ex_addr`  in  AW  effective address (ALU result).
- `ex_wdata`  in  DW  store data (rs2).
- `ex_rd`  in  5  load destination register.
- `dmem_req`  out  1  request valid.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  AW  word-aligned address; [1:0] always 0.
- `dmem_wdata`  out  DW  lane-replicated store data.
- `dmem_wstrb`  out  4  byte enables; 0000 on loads.
- `dmem_gnt`  in  1  memory accepted request.
- `dmem_rvalid`  in  1  load data valid.
- `dmem_rdata`  in  DW  load word.
- `wb_valid`  out  1  one-cycle pulse, load result ready.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  DW  extended load data.
- `misalign`  out  1  one-cycle pulse, rejected access.
- `misalign_addr`  out  AW  offending address.
- `busy`  out  1  high in any state other than IDLE; the core stalls on it.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: `ex_ready`=1.
  - On accept of an aligned, legal op: latch op, address, data and rd, then go to REQ.
  - On accept of a misaligned or illegal op: stay in IDLE and pulse `misalign` with `misalign_addr` the next cycle. No memory access occurs.
- Misaligned means half with addr[0]=1, word with addr[1:0]≠0, or size=11.
- REQ: `dmem_req`=1, with all `dmem_*` outputs held stable until `dmem_gnt`.
  - Store granted: return to IDLE.
  - Load granted: go to WAIT.
- WAIT: on `dmem_rvalid`, register the extracted data, pulse `wb_valid`, return to IDLE.
- `dmem_rvalid` is ignored in IDLE and REQ.
- Store lanes:
  - byte: wdata={4{b}}, wstrb=0001<<addr[1:0].
  - half: wdata={2{h}}, wstrb=0011 (addr[1]=0) or 1100.
  - word: wstrb=1111.
- Load extract:
  - Select byte lane addr[1:0] or half lane addr[1].
  - Sign-extend unless the unsigned bit is set; a word passes through unchanged.
- Loads to rd=0 still pulse `wb_valid`; the register file discards them.

## Timing
- Reset values:
  - State IDLE.
  - `dmem_req`, `dmem_we`, `wb_valid`, `misalign`, `busy` = 0.
  - `dmem_addr`, `dmem_wdata`, `misalign_addr`, `wb_data` = 0.
  - `dmem_wstrb` = 0, `wb_rd` = 0.
  - `ex_ready` = 1 from the first cycle after reset.
- Op accepted at cycle T:
  - `dmem_req` rises at T+1.
  - Minimum load latency: gnt at T+1, rvalid at T+2, `wb_valid` at T+3.
  - Minimum store occupancy: 2 cycles, after which the LSU is back in IDLE at T+2.
- Gnt may be delayed an arbitrary number of cycles; the request is held unchanged.
- Rvalid arrives no earlier than the cycle after gnt.
- `ex_ready`=0 whenever `busy`=1; no op is accepted the same cycle the LSU returns to IDLE.
- Reset mid-operation: the next cycle is IDLE with `dmem_req`=0. A late rvalid from the abandoned load is ignored and produces no `wb_valid`.

## Structure
- Shared package `lsu_pkg` holds:
  - size encodings (SZ_B, SZ_H, SZ_W) and `mem_op` bit indices (OP_UNS=2, OP_ST=3);
  - FSM state encoding.
- One combinational sub-module, `lsu_align`: takes size, unsigned flag, addr[1:0], store data and load word, and produces wdata, wstrb, extracted load data and the misalign flag. The FSM wrapper instantiates it once.

## Test plan
- Word store, addr 0x100, data 0xDEADBEEF, gnt immediate → `dmem_addr`=0x100, `dmem_wstrb`=1111, back in IDLE at T+2.
- Byte store, addr 0x103, data 0x000000A5 → `dmem_wdata`=0xA5A5A5A5, `dmem_wstrb`=1000.
- Signed byte load, addr 0x102, rdata 0x12F03456, rd=5 → `wb_data`=0xFFFFFFF0, `wb_rd`=5 at T+3.
- Unsigned half load, addr 0x206, rdata 0x8001xxxx → `wb_data`=0x00008001. Repeat with gnt delayed 3 cycles → request held stable, `wb_valid` at T+6.
- Word load at 0x101 → `misalign`=1 at T+1, `misalign_addr`=0x101, `dmem_req` never asserted.
- Reset asserted in WAIT, then rvalid pulses → no `wb_valid`, next op accepted normally.
